// File: rtl/fault_campaign_ctrl_if.sv
// fault_campaign_ctrl_if: bundles test-control, datapath and result signals of the fault campaign sequencer.
// FAULT_FIRST_MISS_EN adds the first-undetected-fault report.
interface fault_campaign_ctrl_if #(
   parameter int B_W   = 4,
   parameter int C_W   = 8,
   parameter int LOC_W = 3,
   parameter int CNT_W = 16
);
   logic             start;
   logic             abort;
   logic [B_W-1:0]   b_out;
   logic [LOC_W-1:0] f_loc;
   logic [1:0]       f_type;
   logic [C_W-1:0]   c_in;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] det_cnt;
   logic [CNT_W-1:0] undet_cnt;
`ifdef FAULT_FIRST_MISS_EN
   logic             miss_vld;
   logic [B_W-1:0]   miss_b;
   logic [LOC_W-1:0] miss_loc;
   logic [1:0]       miss_type;
`endif
   modport master (
      input  start, abort, c_in,
`ifdef FAULT_FIRST_MISS_EN
      output miss_vld, miss_b, miss_loc, miss_type,
`endif
      output b_out, f_loc, f_type, busy, done, det_cnt, undet_cnt
   );
   modport slave (
      output start, abort, c_in,
`ifdef FAULT_FIRST_MISS_EN
      input  miss_vld, miss_b, miss_loc, miss_type,
`endif
      input  b_out, f_loc, f_type, busy, done, det_cnt, undet_cnt
   );
endinterface

// File: rtl/fault_campaign_ctrl.sv
// fault_campaign_ctrl: sweeps B x fault location x fault type, compares each faulted C against a golden C.
// Define FAULT_FIRST_MISS_EN to add capture of the first undetected fault of a campaign.
module fault_campaign_ctrl #(
   parameter int B_W   = 4,
   parameter int C_W   = 8,
   parameter int LOC_W = 3,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   fault_campaign_ctrl_if.master bus
);
   typedef enum logic [1:0] {IDLE, GOLD, INJ, DONE} state_e;
   state_e           state_q;
   logic [B_W-1:0]   b_q;
   logic [LOC_W-1:0] loc_q;
   logic [1:0]       type_q;
   logic [C_W-1:0]   golden_q;
   logic [CNT_W-1:0] det_q, det_d, undet_q, undet_d;
   logic             busy_q, done_q, hit;
   assign hit     = bus.c_in != golden_q;
   assign det_d   = (hit && !(&det_q)) ? det_q + 1'b1 : det_q;
   assign undet_d = (!hit && !(&undet_q)) ? undet_q + 1'b1 : undet_q;
   assign bus.b_out     = b_q;
   assign bus.f_loc     = loc_q;
   assign bus.f_type    = type_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.det_cnt   = det_q;
   assign bus.undet_cnt = undet_q;
`ifdef FAULT_FIRST_MISS_EN
   logic             miss_vld_q;
   logic [B_W-1:0]   miss_b_q;
   logic [LOC_W-1:0] miss_loc_q;
   logic [1:0]       miss_type_q;
   assign bus.miss_vld  = miss_vld_q;
   assign bus.miss_b    = miss_b_q;
   assign bus.miss_loc  = miss_loc_q;
   assign bus.miss_type = miss_type_q;
`endif
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         b_q      <= '0;
         loc_q    <= '0;
         type_q   <= '0;
         golden_q <= '0;
         det_q    <= '0;
         undet_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef FAULT_FIRST_MISS_EN
         miss_vld_q  <= 1'b0;
         miss_b_q    <= '0;
         miss_loc_q  <= '0;
         miss_type_q <= '0;
`endif
      end else if (bus.abort) begin
         state_q <= IDLE;
         type_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  state_q <= GOLD;
                  busy_q  <= 1'b1;
                  b_q     <= '0;
                  loc_q   <= '0;
                  type_q  <= '0;
                  det_q   <= '0;
                  undet_q <= '0;
`ifdef FAULT_FIRST_MISS_EN
                  miss_vld_q  <= 1'b0;
                  miss_b_q    <= '0;
                  miss_loc_q  <= '0;
                  miss_type_q <= '0;
`endif
               end
            end
            GOLD: begin
               golden_q <= bus.c_in;
               state_q  <= INJ;
               loc_q    <= '0;
               type_q   <= 2'b01;
            end
            INJ: begin
               det_q   <= det_d;
               undet_q <= undet_d;
`ifdef FAULT_FIRST_MISS_EN
               if (!hit && !miss_vld_q) begin
                  miss_vld_q  <= 1'b1;
                  miss_b_q    <= b_q;
                  miss_loc_q  <= loc_q;
                  miss_type_q <= type_q;
               end
`endif
               if (type_q != 2'b11) begin
                  type_q <= type_q + 1'b1;
               end else if (!(&loc_q)) begin
                  type_q <= 2'b01;
                  loc_q  <= loc_q + 1'b1;
               end else begin
                  // last fault of this B: either finish or capture the next golden
                  type_q <= '0;
                  if (&b_q) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= GOLD;
                     b_q     <= b_q + 1'b1;
                     loc_q   <= '0;
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// tb_fault_campaign_ctrl: randomized self-checking bench comparing fault_campaign_ctrl to a sweep-level model.
module tb_fault_campaign_ctrl;
   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   int         mode  = 0;
   int         n_chk = 0;
   int         n_fail = 0;
   int         det_t [4];
   logic [7:0] tbl [384];
   always #5 clk = ~clk;
   fault_campaign_ctrl_if bus ();
   fault_campaign_ctrl_if #(.CNT_W(8)) bus8 ();
   fault_campaign_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
   fault_campaign_ctrl #(.CNT_W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
   // mode 0: real stuck/flip datapath, 1: fault-free, 2: random per-fault corruption table
   function automatic logic [7:0] dp(input int m, input int b, input int l, input int t);
      logic [7:0] c = 8'(b * b);
      logic [7:0] msk = 8'(1 << l);
      if (t == 0 || m == 1) return c;
      if (m == 2) return c ^ tbl[b * 24 + l * 3 + t - 1];
      return t == 1 ? c & ~msk : t == 2 ? c | msk : c ^ msk;
   endfunction
   assign bus.c_in   = dp(mode, int'(bus.b_out), int'(bus.f_loc), int'(bus.f_type));
   assign bus8.c_in  = dp(mode, int'(bus8.b_out), int'(bus8.f_loc), int'(bus8.f_type));
   assign bus8.start = bus.start;
   assign bus8.abort = bus.abort;
   task automatic model(input int m, input int n, output int det, output int undet, output logic [9:0] miss);
      det = 0; undet = 0; miss = '0;
      for (int i = 0; i < n && i < 400; i++) begin
         int b = i / 25;
         int r = i % 25;
         if (r != 0) begin
            int l = (r - 1) / 3;
            int t = (r - 1) % 3 + 1;
            if (dp(m, b, l, t) != dp(m, b, 0, 0)) det++;
            else begin
               undet++;
               if (!miss[9]) miss = {1'b1, 4'(b), 3'(l), 2'(t)};
            end
         end
      end
   endtask
   task automatic run(input int abort_at, input int start_at, output int cyc);
      int pdet = 0, ptype = 0, pb = 0, bad = 0, eb, el, et;
      bit pinj = 0, ebusy, edone;
      foreach (det_t[k]) det_t[k] = 0;
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      cyc = 0;
      while (1) begin
         ebusy = cyc < 400;
         edone = cyc == 400;
         eb = ebusy ? cyc / 25 : 15;
         el = ebusy ? (cyc % 25 == 0 ? 0 : (cyc % 25 - 1) / 3) : 7;
         et = (ebusy && cyc % 25 != 0) ? (cyc % 25 - 1) % 3 + 1 : 0;
         if ({bus.b_out, bus.f_loc, bus.f_type, bus.busy, bus.done} !== {4'(eb), 3'(el), 2'(et), ebusy, edone}) begin
            if (bad == 0)
               $display("trace deviation at cycle %0d: b=%0d loc=%0d type=%0d busy=%b done=%b, want b=%0d loc=%0d type=%0d busy=%b done=%b",
                        cyc, bus.b_out, bus.f_loc, bus.f_type, bus.busy, bus.done, eb, el, et, ebusy, edone);
            bad++;
         end
         if (pinj && pb == 5) det_t[ptype] += int'(bus.det_cnt) - pdet;
         pinj  = bus.busy && bus.f_type != 0;
         ptype = int'(bus.f_type);
         pb    = int'(bus.b_out);
         pdet  = int'(bus.det_cnt);
         if (bus.done || cyc == abort_at || cyc >= 1000) break;
         bus.start = cyc == start_at;
         @(negedge clk);
         cyc++;
      end
      bus.start = 1'b0;
      n_chk++;
      if (bad != 0) begin n_fail++; $display("FAIL trace: %0d deviating cycles, required 0", bad); end
   endtask
   task automatic check_counts(input string name, input int det, input int undet);
      n_chk++;
      if (bus.det_cnt !== 16'(det) || bus.undet_cnt !== 16'(undet)) begin
         n_fail++;
         $display("FAIL %s counts: det=%0d undet=%0d, required det=%0d undet=%0d", name, bus.det_cnt, bus.undet_cnt, det, undet);
      end
   endtask
   task automatic test_reset;
      #12;
      n_chk++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL reset flags: busy=%b done=%b, required 0 0", bus.busy, bus.done); end
      n_chk++;
      if ({bus.b_out, bus.f_loc, bus.f_type} !== 9'd0) begin n_fail++; $display("FAIL reset operands: %h, required 0", {bus.b_out, bus.f_loc, bus.f_type}); end
      check_counts("reset", 0, 0);
      @(negedge clk) reset = 1'b0;
   endtask
   task automatic test_real;
      int cyc, det, undet;
      logic [9:0] miss;
      mode = 0;
      run(-1, -1, cyc);
      model(0, 400, det, undet, miss);
      n_chk++;
      if (cyc != 400) begin n_fail++; $display("FAIL real latency: %0d cycles, required 400", cyc); end
      check_counts("real", det, undet);
      n_chk++;
      if (det_t[1] != 3 || det_t[2] != 5 || det_t[3] != 8) begin
         n_fail++;
         $display("FAIL b5 per-type: %0d/%0d/%0d, required 3/5/8", det_t[1], det_t[2], det_t[3]);
      end
      n_chk++;
      if (bus8.det_cnt !== 8'(det > 255 ? 255 : det) || bus8.undet_cnt !== 8'(undet)) begin
         n_fail++;
         $display("FAIL saturation: det=%0d undet=%0d, required det=%0d undet=%0d", bus8.det_cnt, bus8.undet_cnt, det > 255 ? 255 : det, undet);
      end
`ifdef FAULT_FIRST_MISS_EN
      n_chk++;
      if ({bus.miss_vld, bus.miss_b, bus.miss_loc, bus.miss_type} !== miss) begin
         n_fail++;
         $display("FAIL real first miss: %h, required %h", {bus.miss_vld, bus.miss_b, bus.miss_loc, bus.miss_type}, miss);
      end
`endif
      @(negedge clk);
      n_chk++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.b_out !== 4'd15 || bus.f_loc !== 3'd7 || bus.f_type !== 2'd0) begin
         n_fail++;
         $display("FAIL done hold: done=%b busy=%b b=%0d loc=%0d type=%0d, required 0 0 15 7 0", bus.done, bus.busy, bus.b_out, bus.f_loc, bus.f_type);
      end
      check_counts("done hold", det, undet);
   endtask
   task automatic test_fault_free;
      int cyc, det, undet;
      logic [9:0] miss;
      mode = 1;
      run(-1, int'($urandom_range(398, 1)), cyc);
      model(1, 400, det, undet, miss);
      check_counts("fault-free", det, undet);
   endtask
   task automatic test_back_to_back;
      int cyc, det, undet;
      logic [9:0] miss;
      for (int it = 0; it < 3; it++) begin
         foreach (tbl[k]) tbl[k] = $urandom_range(1, 0) != 0 ? 8'($urandom_range(255, 1)) : 8'h00;
         mode = 2;
         run(-1, int'($urandom_range(398, 1)), cyc);
         model(2, 400, det, undet, miss);
         n_chk++;
         if (cyc != 400) begin n_fail++; $display("FAIL random latency %0d: %0d cycles, required 400", it, cyc); end
         check_counts("random", det, undet);
`ifdef FAULT_FIRST_MISS_EN
         n_chk++;
         if ({bus.miss_vld, bus.miss_b, bus.miss_loc, bus.miss_type} !== miss) begin
            n_fail++;
            $display("FAIL random first miss %0d: %h, required %h", it, {bus.miss_vld, bus.miss_b, bus.miss_loc, bus.miss_type}, miss);
         end
`endif
      end
   endtask
   task automatic test_abort(input int at);
      int cyc, det, undet, det2, undet2;
      logic [9:0] miss;
      bit seen_done = 0;
      mode = 0;
      run(at, -1, cyc);
      bus.abort = 1'b1;
      @(negedge clk) bus.abort = 1'b0;
      model(0, at, det, undet, miss);
      n_chk++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.f_type !== 2'd0) begin
         n_fail++;
         $display("FAIL abort@%0d state: busy=%b done=%b type=%0d, required 0 0 0", at, bus.busy, bus.done, bus.f_type);
      end
      check_counts("abort", det, undet);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen_done = 1;
      end
      n_chk++;
      if (seen_done) begin n_fail++; $display("FAIL abort@%0d idle: busy/done seen after abort, required both 0", at); end
      check_counts("abort frozen", det, undet);
      run(-1, -1, cyc);
      model(0, 400, det2, undet2, miss);
      n_chk++;
      if (cyc != 400) begin n_fail++; $display("FAIL rerun latency: %0d cycles, required 400", cyc); end
      check_counts("rerun", det2, undet2);
   endtask
   task automatic test_reset_mid;
      int cyc;
      mode = 0;
      run(60, -1, cyc);
      #2 reset = 1'b1;
      #1;
      n_chk++;
      if ({bus.b_out, bus.f_loc, bus.f_type, bus.busy, bus.done} !== 11'd0) begin
         n_fail++;
         $display("FAIL async reset outputs: %h, required 0", {bus.b_out, bus.f_loc, bus.f_type, bus.busy, bus.done});
      end
      check_counts("async reset", 0, 0);
`ifdef FAULT_FIRST_MISS_EN
      n_chk++;
      if (bus.miss_vld !== 1'b0) begin n_fail++; $display("FAIL async reset miss_vld: %b, required 0", bus.miss_vld); end
`endif
      @(negedge clk) reset = 1'b0;
      @(negedge clk);
      n_chk++;
      if (bus.busy !== 1'b0 || bus.f_type !== 2'd0) begin
         n_fail++;
         $display("FAIL post-reset idle: busy=%b type=%0d, required 0 0", bus.busy, bus.f_type);
      end
   endtask
   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      test_reset;
      test_real;
      test_fault_free;
      test_back_to_back;
      test_abort(100);
      test_abort(int'($urandom_range(399, 1)));
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
